sample_avg_spi: RTL and testbench

SAMPLE_AVG_SPI -- requirements
Module: sample_avg_spi

---
 rtl/sample_avg_spi_pkg.sv | 20 ++
 rtl/spi_frame_tx.sv | 122 ++++++++++++
 rtl/sample_avg_spi.sv | 102 ++++++++++
 tb/tb_sample_avg_spi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_avg_spi_pkg.sv
// Shared definitions for the sample averager and its SPI frame transmitter.
//   CodeWidth  - width of one conversion code
//   FrameWidth - width of one SPI frame: {sequence, result}
//   SeqWidth   - width of the frame sequence number
//   tx_state_e - transmitter FSM states
package sample_avg_spi_pkg;

    localparam int unsigned CodeWidth  = 8;
    localparam int unsigned FrameWidth = 16;
    localparam int unsigned SeqWidth   = FrameWidth - CodeWidth;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StShift,
        StTrail,
        StGap
    } tx_state_e;

endpackage

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter: clock divider, 16-bit shift register and framing FSM.
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   start    - load frame and begin transmission (ignored unless idle)
//   frame    - frame to send, MSB first
//   spi_csn  - chip select, active-low (registered)
//   spi_clk  - SPI clock, idle low (registered)
//   spi_mosi - serial data, forced low while spi_csn is high (registered)
//   busy     - high in every state other than idle (registered)
module spi_frame_tx
    import sample_avg_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FrameWidth-1:0] frame,
    output logic                  spi_csn,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  busy
);

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    tx_state_e             state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [4:0]            half_q, half_d;
    logic [FrameWidth-1:0] shreg_q, shreg_d;
    logic                  csn_q, csn_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  tick;

    assign tick = (div_q == DivLast);

    always_comb begin
        state_d = state_q;
        div_d   = 8'd0;
        half_d  = half_q;
        shreg_d = shreg_q;

        if (state_q != StIdle) begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d = frame;
                    half_d  = 5'd0;
                    state_d = StLead;
                end
            end
            StLead: begin
                if (tick) begin
                    state_d = StShift;
                end
            end
            // 32 half-periods, even = low, odd = high. Leaving an odd half is a
            // falling edge: advance data there; the 16th fall enters TRAIL.
            StShift: begin
                if (tick) begin
                    half_d = half_q + 5'd1;
                    if (half_q[0]) begin
                        shreg_d = {shreg_q[FrameWidth-2:0], 1'b0};
                    end
                    if (half_q == 5'd31) begin
                        state_d = StTrail;
                    end
                end
            end
            StTrail: begin
                if (tick) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from next state so they land in flops.
        csn_d  = !(state_d inside {StLead, StShift, StTrail});
        sclk_d = (state_d == StShift) && half_d[0];
        mosi_d = !csn_d && shreg_d[FrameWidth-1];
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            div_q   <= 8'd0;
            half_q  <= 5'd0;
            shreg_q <= '0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            shreg_q <= shreg_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
        end
    end

    assign spi_csn  = csn_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;

endmodule

// File: rtl/sample_avg_spi.sv
// Averages 2^N_AVG_LOG2 conversion codes and sends each average as a 16-bit SPI frame
// {sequence, result}. Results completing while a frame is in flight are dropped.
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   code       - conversion code
//   code_valid - one-cycle strobe qualifying code
//   spi_csn    - SPI chip select, active-low
//   spi_clk    - SPI clock, mode 0
//   spi_mosi   - SPI data, MSB first
//   busy       - frame in flight
//   overrun    - sticky: a completed average was dropped
module sample_avg_spi
    import sample_avg_spi_pkg::*;
#(
    parameter int unsigned N_AVG_LOG2 = 2,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CodeWidth-1:0] code,
    input  logic                 code_valid,
    output logic                 spi_csn,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned AccW = CodeWidth + N_AVG_LOG2;
    // Keep a 1-bit counter when averaging a single sample.
    localparam int unsigned CntW = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << N_AVG_LOG2) - 1);

    logic [AccW-1:0]      acc_q, acc_d, sum;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SeqWidth-1:0]  seq_q, seq_d;
    logic                 overrun_q, overrun_d;
    logic [CodeWidth-1:0] result;
    logic                 complete;
    logic                 start;
    logic                 tx_busy;

    assign sum      = acc_q + AccW'(code);
    assign result   = CodeWidth'(sum >> N_AVG_LOG2);
    assign complete = code_valid && (cnt_q == CntLast);
    assign start    = complete && !tx_busy;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        overrun_d = overrun_q;

        if (code_valid) begin
            if (complete) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntW'(1);
            end
        end

        if (start) begin
            seq_d = seq_q + SeqWidth'(1);
        end
        if (complete && tx_busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            seq_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
        end
    end

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame    ({seq_q, result}),
        .spi_csn  (spi_csn),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .busy     (tx_busy)
    );

    assign busy    = tx_busy;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sample_avg_spi.sv
// Scoreboard bench: stimulus pushes expected frames, SPI monitors pop and compare.
// dut_a: N_AVG_LOG2=2, CLK_DIV=2.  dut_b: N_AVG_LOG2=0, CLK_DIV=1.
module tb_sample_avg_spi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] code_a = 8'd0, code_b = 8'd0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       csn_a, sclk_a, mosi_a, busy_a, ovr_a;
    logic       csn_b, sclk_b, mosi_b, busy_b, ovr_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    always #5 clk = ~clk;

    sample_avg_spi #(.N_AVG_LOG2(2), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .code(code_a), .code_valid(valid_a),
        .spi_csn(csn_a), .spi_clk(sclk_a), .spi_mosi(mosi_a), .busy(busy_a), .overrun(ovr_a)
    );

    sample_avg_spi #(.N_AVG_LOG2(0), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .code(code_b), .code_valid(valid_b),
        .spi_csn(csn_b), .spi_clk(sclk_b), .spi_mosi(mosi_b), .busy(busy_b), .overrun(ovr_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic [15:0] sh_a, sh_b;
    int          nb_a, nb_b, low_a, low_b;
    bit          act_a, act_b, pclk_a, pclk_b;

    always @(negedge clk) begin
        if (!rst) begin
            act_a = 1'b0;
        end else if (!csn_a) begin
            if (!act_a) begin
                act_a = 1'b1; sh_a = 16'h0; nb_a = 0; low_a = 0;
            end
            low_a++;
            if (sclk_a && !pclk_a) begin
                sh_a = {sh_a[14:0], mosi_a};
                nb_a++;
            end
        end else begin
            check("a_mosi_idle", 32'(mosi_a), 32'd0);
            if (act_a) begin
                act_a = 1'b0;
                if (exp_a.size() == 0) begin
                    check("a_unexpected_frame", 32'(sh_a), 32'hFFFF_FFFF);
                end else begin
                    check("a_frame", 32'(sh_a), 32'(exp_a.pop_front()));
                    check("a_rise_edges", 32'(nb_a), 32'd16);
                    check("a_csn_low_cycles", 32'(low_a), 32'd68);
                end
            end
        end
        pclk_a = sclk_a;
    end

    always @(negedge clk) begin
        if (!rst) begin
            act_b = 1'b0;
        end else if (!csn_b) begin
            if (!act_b) begin
                act_b = 1'b1; sh_b = 16'h0; nb_b = 0; low_b = 0;
            end
            low_b++;
            if (sclk_b && !pclk_b) begin
                sh_b = {sh_b[14:0], mosi_b};
                nb_b++;
            end
        end else begin
            check("b_mosi_idle", 32'(mosi_b), 32'd0);
            if (act_b) begin
                act_b = 1'b0;
                if (exp_b.size() == 0) begin
                    check("b_unexpected_frame", 32'(sh_b), 32'hFFFF_FFFF);
                end else begin
                    check("b_frame", 32'(sh_b), 32'(exp_b.pop_front()));
                    check("b_rise_edges", 32'(nb_b), 32'd16);
                    check("b_csn_low_cycles", 32'(low_b), 32'd34);
                end
            end
        end
        pclk_b = sclk_b;
    end

    // ---------------- stimulus ----------------
    task automatic send_a(input logic [7:0] c);
        code_a = c; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
    endtask

    task automatic group_a(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        send_a(c0); send_a(c1); send_a(c2); send_a(c3);
    endtask

    task automatic send_b(input logic [7:0] c);
        code_b = c; valid_b = 1'b1;
        @(posedge clk); #1;
        valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b, input string name);
        int n = 0;
        while ((sel_b ? busy_b : busy_a) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            n_checks++; n_fail++;
            $display("FAIL %s: busy still high after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_csn_a"}, 32'(csn_a), 32'd1);
        check({tag, "_sclk_a"}, 32'(sclk_a), 32'd0);
        check({tag, "_mosi_a"}, 32'(mosi_a), 32'd0);
        check({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        check({tag, "_ovr_a"}, 32'(ovr_a), 32'd0);
        check({tag, "_csn_b"}, 32'(csn_b), 32'd1);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        check({tag, "_ovr_b"}, 32'(ovr_b), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic average: (10+11+12+13)/4 = 11, sequence 0.
        exp_a.push_back(16'h000B);
        group_a(8'd10, 8'd11, 8'd12, 8'd13);
        check("a_busy_after_load", 32'(busy_a), 32'd1);
        wait_idle(1'b0, "a_idle_1");

        // Full-scale codes must not overflow the accumulator.
        exp_a.push_back(16'h01FF);
        group_a(8'd255, 8'd255, 8'd255, 8'd255);
        wait_idle(1'b0, "a_idle_2");

        // Second group lands while busy: dropped, overrun, sequence not consumed.
        exp_a.push_back(16'h0204);
        group_a(8'd4, 8'd4, 8'd4, 8'd4);
        check("a_ovr_before", 32'(ovr_a), 32'd0);
        group_a(8'd1, 8'd1, 8'd1, 8'd1);
        check("a_ovr_set", 32'(ovr_a), 32'd1);
        wait_idle(1'b0, "a_idle_3");
        check("a_ovr_sticky", 32'(ovr_a), 32'd1);
        exp_a.push_back(16'h0308);
        group_a(8'd8, 8'd8, 8'd8, 8'd8);
        wait_idle(1'b0, "a_idle_4");

        // Reset mid-frame (around bit 7) with a partial accumulation pending.
        group_a(8'd20, 8'd20, 8'd20, 8'd20);
        send_a(8'd100);
        send_a(8'd100);
        repeat (33) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        reset_checks("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        // (40+41+42+43)/4 = 41; sequence restarts at 0.
        exp_a.push_back(16'h0029);
        group_a(8'd40, 8'd41, 8'd42, 8'd43);
        wait_idle(1'b0, "a_idle_5");

        // Single-sample averaging, fastest clock, then sequence wrap.
        exp_b.push_back(16'h00A5);
        send_b(8'hA5);
        wait_idle(1'b1, "b_idle_first");
        for (int i = 1; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            exp_b.push_back({v, v});
            send_b(v);
            wait_idle(1'b1, "b_idle_loop");
        end
        exp_b.push_back(16'h005A);
        send_b(8'h5A);
        wait_idle(1'b1, "b_idle_wrap");

        repeat (5) @(posedge clk); #1;
        check("b_ovr_final", 32'(ovr_b), 32'd0);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
